reg_file_2r1w: RTL and testbench
================================

# reg_file_2r1w

General-purpose register file for the single-cycle core: two combinational read ports feeding the ALU operands, one clocked write port driven by writeback. Register 0 is hardwired to zero, RISC-style. The block sits between decode (register indices) and execute/writeback.

## Interface
Parameters:
- `REGISTER_WIDTH`, 32, data width of each register.
- `REG_INDEX_WIDTH`, 5, index width; depth is `NUM_REGS = 2**REG_INDEX_WIDTH` (32).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wr_en`  in  1  write enable, sampled at the rising edge of `clk`.
- `wr_reg_index`  in  `REG_INDEX_WIDTH`  destination register.
- `wr_reg_data`  in  `REGISTER_WIDTH`  write data.
- `rd_reg_index_1`  in  `REG_INDEX_WIDTH`  read port 1 index.
- `rd_reg_index_2`  in  `REG_INDEX_WIDTH`  read port 2 index.
- `reg_data_1`  out  `REGISTER_WIDTH`  read port 1 data.
- `reg_data_2`  out  `REGISTER_WIDTH`  read port 2 data.

## Operation
- Storage: `NUM_REGS` registers of `REGISTER_WIDTH` bits.
- Reset: at a rising edge with `rst`=1, all registers clear to 0.
- Write: at a rising edge with `rst`=0, `wr_en`=1 and `wr_reg_index`≠0, the addressed register loads `wr_reg_data`.
- A write with `wr_reg_index`=0 is discarded. Register 0 always reads 0.
- Read: `reg_data_N` is a purely combinational function of `rd_reg_index_N` and the current register contents. An index of 0 returns 0.
- Both ports are independent. Both may address the same register, and both may address the write target.
- Any `wr_en` value with unknown or X index must not corrupt other registers in simulation. An X index produces X data only on the port that reads it.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: 1 edge. The new value is visible on a read port immediately after the capturing edge.
- Reset has priority over write. If `rst`=1 and `wr_en`=1 on the same edge, all registers end at 0.
- Asserting `rst` mid-sequence wipes all previously written values at that edge. Outputs reflect 0 within the same delta once the edge completes.
- Read-during-write to the same index in the same cycle, without bypass: the old value is read until the edge.
- A `wr_en` pulse narrower than a clock period takes effect only if it is high at a rising edge.
- Reset values of outputs: `reg_data_1` = `reg_data_2` = 0 after reset, for any index.

## Configuration
- `REG_FILE_BYPASS_EN` defined: write-through forwarding applies to each read port. When `wr_en`=1, `rst`=0, `wr_reg_index`≠0 and `wr_reg_index` equals `rd_reg_index_N`, `reg_data_N` returns `wr_reg_data` combinationally in the same cycle.
- Bypass never applies to index 0.
- `REG_FILE_BYPASS_EN` undefined: reads return stored contents only, as in Timing.

## Structure
- Shared package `reg_file_pkg`:
  - `REGISTER_WIDTH` and `REG_INDEX_WIDTH` defaults, also used by decode and ALU.
  - `NUM_REGS`.
  - Typedefs `reg_data_t` and `reg_index_t`.
  - Constant `ZERO_REG_INDEX` = 0.
- One sub-module, `reg_file_read_port`, instantiated twice. It holds the index decode, the zero-register override and the optional bypass mux.
- Top level holds the storage array and the write/reset logic.

## Test plan
- Hold `rst`=1 for one edge, then read indices 10 and 15 -> `reg_data_1` = `reg_data_2` = 0.
- Write 1234 to index 5 with a one-edge `wr_en` pulse, then read index 5 on port 1 -> 1234. Port 2 on index 15 stays 0.
- Write 2431 to index 0, then read index 0 on both ports -> 0.
- Write distinct values to indices 1..31, then read all pairs (i, 31−i) -> each port returns its stored value.
- Assert `rst`=1 and `wr_en`=1 (index 7, data 99) on the same edge, then read 7 -> 0. Also read 5, previously written 1234 -> 0.
- Bypass: `wr_en`=1, index 9, data 555, both read indices 9, before the edge:
  - built with `REG_FILE_BYPASS_EN` -> 555 on both ports;
  - built without it -> old value 0;
  - after the edge, both builds -> 555.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file definitions used by decode, ALU and the register file itself.
package reg_file_pkg;

  localparam int REGISTER_WIDTH  = 32;
  localparam int REG_INDEX_WIDTH = 5;
  localparam int NUM_REGS        = 2 ** REG_INDEX_WIDTH;

  typedef logic [REGISTER_WIDTH-1:0]  reg_data_t;
  typedef logic [REG_INDEX_WIDTH-1:0] reg_index_t;

  localparam reg_index_t ZERO_REG_INDEX = '0;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Register-file access bus: one write port from writeback, two read ports to execute.
interface reg_file_2r1w_if #(
  parameter int REGISTER_WIDTH  = reg_file_pkg::REGISTER_WIDTH,
  parameter int REG_INDEX_WIDTH = reg_file_pkg::REG_INDEX_WIDTH
);

  logic                       wr_en;
  logic [REG_INDEX_WIDTH-1:0] wr_reg_index;
  logic [REGISTER_WIDTH-1:0]  wr_reg_data;
  logic [REG_INDEX_WIDTH-1:0] rd_reg_index_1;
  logic [REG_INDEX_WIDTH-1:0] rd_reg_index_2;
  logic [REGISTER_WIDTH-1:0]  reg_data_1;
  logic [REGISTER_WIDTH-1:0]  reg_data_2;

  modport master (
    output wr_en, wr_reg_index, wr_reg_data, rd_reg_index_1, rd_reg_index_2,
    input  reg_data_1, reg_data_2
  );

  modport slave (
    input  wr_en, wr_reg_index, wr_reg_data, rd_reg_index_1, rd_reg_index_2,
    output reg_data_1, reg_data_2
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port: index decode, register-0 override and, when
// REG_FILE_BYPASS_EN is defined, write-through forwarding from the write port.
module reg_file_read_port #(
  parameter int REGISTER_WIDTH  = 32,
  parameter int REG_INDEX_WIDTH = 5
) (
  input  logic [(2**REG_INDEX_WIDTH)-1:0][REGISTER_WIDTH-1:0] regs,
  input  logic [REG_INDEX_WIDTH-1:0]                          rd_index,
`ifdef REG_FILE_BYPASS_EN
  input  logic                                                rst,
  input  logic                                                wr_en,
  input  logic [REG_INDEX_WIDTH-1:0]                          wr_index,
  input  logic [REGISTER_WIDTH-1:0]                           wr_data,
`endif
  output logic [REGISTER_WIDTH-1:0]                           rd_data
);

  import reg_file_pkg::*;

  logic rd_is_zero;

  assign rd_is_zero = (rd_index == REG_INDEX_WIDTH'(ZERO_REG_INDEX));

  // An X index selects X from the array and leaves every compare below unresolved,
  // so only this port sees X.
  always_comb begin
    // NOTE: assigning a default first on every path keeps this block free of latches.
    rd_data = regs[rd_index];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && !rst && (wr_index == rd_index)) begin
      rd_data = wr_data;
    end
`endif
    if (rd_is_zero) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with register 0 hardwired to zero.
// Optional write-through forwarding on both read ports via REG_FILE_BYPASS_EN.
module reg_file_2r1w #(
  parameter int REGISTER_WIDTH  = reg_file_pkg::REGISTER_WIDTH,
  parameter int REG_INDEX_WIDTH = reg_file_pkg::REG_INDEX_WIDTH
) (
  input logic             clk,
  input logic             rst,
  reg_file_2r1w_if.slave  bus
);

  localparam int NUM_REGS = 2 ** REG_INDEX_WIDTH;

  logic [NUM_REGS-1:0][REGISTER_WIDTH-1:0] regs_d;
  logic [NUM_REGS-1:0][REGISTER_WIDTH-1:0] regs_q;

  // Entry 0 is never loaded, so it holds its reset value of zero forever. Each entry
  // compares against the write index on its own, so an X index corrupts nothing.
  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      regs_d = '0;
    end else if (bus.wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (bus.wr_reg_index == REG_INDEX_WIDTH'(i)) begin
          regs_d[i] = bus.wr_reg_data;
        end
      end
    end
  end

  // NOTE: the whole array is reset because software relies on every register reading
  // zero after reset; without that requirement the data flops would be left unreset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    regs_q <= regs_d;
  end

  reg_file_read_port #(
    .REGISTER_WIDTH  (REGISTER_WIDTH),
    .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
  ) u_read_port_1 (
    .regs     (regs_q),
    .rd_index (bus.rd_reg_index_1),
`ifdef REG_FILE_BYPASS_EN
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_index (bus.wr_reg_index),
    .wr_data  (bus.wr_reg_data),
`endif
    .rd_data  (bus.reg_data_1)
  );

  reg_file_read_port #(
    .REGISTER_WIDTH  (REGISTER_WIDTH),
    .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
  ) u_read_port_2 (
    .regs     (regs_q),
    .rd_index (bus.rd_reg_index_2),
`ifdef REG_FILE_BYPASS_EN
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_index (bus.wr_reg_index),
    .wr_data  (bus.wr_reg_data),
`endif
    .rd_data  (bus.reg_data_2)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios plus randomized traffic
// checked against an array model of the architectural register state.
module tb_reg_file_2r1w;

  logic clk;
  logic rst;

  reg_file_2r1w_if #(.REGISTER_WIDTH(32), .REG_INDEX_WIDTH(5)) bus ();

  reg_file_2r1w #(.REGISTER_WIDTH(32), .REG_INDEX_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned errors;
  logic [31:0] mdl [32];

  // Expected read value: index 0 is zero, a forwarded write wins when bypass is built
  // in, otherwise whatever the model holds.
  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
    if (bus.wr_en && !rst && bus.wr_reg_index == idx) return bus.wr_reg_data;
`endif
    return mdl[idx];
  endfunction

  // One rising edge; the model takes the write/reset seen at that edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    end else if (bus.wr_en && bus.wr_reg_index != 5'd0) begin
      mdl[bus.wr_reg_index] = bus.wr_reg_data;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0;
    bus.wr_reg_index = 5'd0;
    bus.wr_reg_data = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] got1, got2;
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    bus.rd_reg_index_1 = 5'd10;
    bus.rd_reg_index_2 = 5'd15;
    #1;
    got1 = bus.reg_data_1;
    got2 = bus.reg_data_2;
    vectors += 2;
    if (got1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_port1: got %0h expected 0", got1);
    end
    if (got2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_port2: got %0h expected 0", got2);
    end
  endtask

  task automatic test_single_write();
    logic [31:0] got1, got2;
    bus.wr_en = 1'b1;
    bus.wr_reg_index = 5'd5;
    bus.wr_reg_data = 32'd1234;
    step();
    idle_inputs();
    bus.rd_reg_index_1 = 5'd5;
    bus.rd_reg_index_2 = 5'd15;
    #1;
    got1 = bus.reg_data_1;
    got2 = bus.reg_data_2;
    vectors += 2;
    if (got1 !== 32'd1234) begin
      errors++;
      $display("FAIL write5_port1: got %0d expected 1234", got1);
    end
    if (got2 !== 32'd0) begin
      errors++;
      $display("FAIL idx15_port2: got %0d expected 0", got2);
    end
    // A wr_en pulse that drops before the next edge must not write.
    bus.wr_reg_index = 5'd15;
    bus.wr_reg_data = 32'hdead_beef;
    bus.wr_en = 1'b1;
    #2;
    bus.wr_en = 1'b0;
    step();
    got2 = bus.reg_data_2;
    vectors++;
    if (got2 !== 32'd0) begin
      errors++;
      $display("FAIL narrow_pulse: got %0h expected 0", got2);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    logic [31:0] got1, got2;
    bus.wr_en = 1'b1;
    bus.wr_reg_index = 5'd0;
    bus.wr_reg_data = 32'd2431;
    step();
    idle_inputs();
    bus.rd_reg_index_1 = 5'd0;
    bus.rd_reg_index_2 = 5'd0;
    #1;
    got1 = bus.reg_data_1;
    got2 = bus.reg_data_2;
    vectors += 2;
    if (got1 !== 32'd0) begin
      errors++;
      $display("FAIL zero_reg_port1: got %0d expected 0", got1);
    end
    if (got2 !== 32'd0) begin
      errors++;
      $display("FAIL zero_reg_port2: got %0d expected 0", got2);
    end
  endtask

  task automatic test_fill_pairs();
    logic [31:0] got1, got2, want1, want2;
    for (int i = 1; i < 32; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_reg_index = 5'(i);
      bus.wr_reg_data = 32'h1000_0000 + 32'(i) * 32'd4099;
      step();
    end
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      bus.rd_reg_index_1 = 5'(i);
      bus.rd_reg_index_2 = 5'(31 - i);
      #1;
      got1 = bus.reg_data_1;
      got2 = bus.reg_data_2;
      want1 = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i) * 32'd4099;
      want2 = (i == 31) ? 32'd0 : 32'h1000_0000 + 32'(31 - i) * 32'd4099;
      vectors += 2;
      if (got1 !== want1) begin
        errors++;
        $display("FAIL pair_port1 idx %0d: got %0h expected %0h", i, got1, want1);
      end
      if (got2 !== want2) begin
        errors++;
        $display("FAIL pair_port2 idx %0d: got %0h expected %0h", 31 - i, got2, want2);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [31:0] got1, got2;
    // Restore 1234 in register 5 so the wipe is observable.
    bus.wr_en = 1'b1;
    bus.wr_reg_index = 5'd5;
    bus.wr_reg_data = 32'd1234;
    step();
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_reg_index = 5'd7;
    bus.wr_reg_data = 32'd99;
    step();
    rst = 1'b0;
    idle_inputs();
    bus.rd_reg_index_1 = 5'd7;
    bus.rd_reg_index_2 = 5'd5;
    #1;
    got1 = bus.reg_data_1;
    got2 = bus.reg_data_2;
    vectors += 2;
    if (got1 !== 32'd0) begin
      errors++;
      $display("FAIL rst_over_write idx7: got %0d expected 0", got1);
    end
    if (got2 !== 32'd0) begin
      errors++;
      $display("FAIL rst_wipe idx5: got %0d expected 0", got2);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] got1, got2, want;
`ifdef REG_FILE_BYPASS_EN
    want = 32'd555;
`else
    want = 32'd0;
`endif
    bus.wr_en = 1'b1;
    bus.wr_reg_index = 5'd9;
    bus.wr_reg_data = 32'd555;
    bus.rd_reg_index_1 = 5'd9;
    bus.rd_reg_index_2 = 5'd9;
    #1;
    got1 = bus.reg_data_1;
    got2 = bus.reg_data_2;
    vectors += 2;
    if (got1 !== want) begin
      errors++;
      $display("FAIL bypass_pre_port1: got %0d expected %0d", got1, want);
    end
    if (got2 !== want) begin
      errors++;
      $display("FAIL bypass_pre_port2: got %0d expected %0d", got2, want);
    end
    step();
    idle_inputs();
    #1;
    got1 = bus.reg_data_1;
    got2 = bus.reg_data_2;
    vectors += 2;
    if (got1 !== 32'd555) begin
      errors++;
      $display("FAIL bypass_post_port1: got %0d expected 555", got1);
    end
    if (got2 !== 32'd555) begin
      errors++;
      $display("FAIL bypass_post_port2: got %0d expected 555", got2);
    end
  endtask

  task automatic test_random();
    logic [31:0] got1, got2, want1, want2;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.wr_en = $urandom_range(0, 2) != 0;
      bus.wr_reg_index = 5'($urandom_range(0, 31));
      bus.wr_reg_data = $urandom;
      bus.rd_reg_index_1 = ($urandom_range(0, 3) == 0) ? bus.wr_reg_index : 5'($urandom_range(0, 31));
      bus.rd_reg_index_2 = ($urandom_range(0, 3) == 0) ? bus.wr_reg_index : 5'($urandom_range(0, 31));
      #1;
      got1 = bus.reg_data_1;
      got2 = bus.reg_data_2;
      want1 = exp_rd(bus.rd_reg_index_1);
      want2 = exp_rd(bus.rd_reg_index_2);
      vectors += 2;
      if (got1 !== want1) begin
        errors++;
        $display("FAIL random_port1 n=%0d idx %0d: got %0h expected %0h",
                 n, bus.rd_reg_index_1, got1, want1);
      end
      if (got2 !== want2) begin
        errors++;
        $display("FAIL random_port2 n=%0d idx %0d: got %0h expected %0h",
                 n, bus.rd_reg_index_2, got2, want2);
      end
      step();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    rst = 1'b1;
    idle_inputs();
    bus.rd_reg_index_1 = 5'd0;
    bus.rd_reg_index_2 = 5'd0;
    test_reset();
    test_single_write();
    test_zero_reg();
    test_fill_pairs();
    test_reset_priority();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
